// File: rtl/ak16_pkg.sv
// Shared definitions for the memory-stage controller: FSM encoding, width
// defaults and the timeout counter sizing helper.
package ak16_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned REG_W_DEF  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // Counter must hold 0..TIMEOUT-1; keep at least one bit when timeout is off.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: decodes load/store control, runs the req/ack data
// port with optional timeout, resolves branches and registers MEM/WB outputs.
module mem_stage_ctrl
  import ak16_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rs2_data,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic              mem_mem_write,
  input  logic              mem_mem_to_reg,
  input  logic              mem_branch,
  input  logic              mem_branch_ne,
  input  logic              mem_zero,
  output logic              stall_mem,
  output logic              branch_taken,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] wb_result,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_reg_write,
  output logic              mem_fault
);

  localparam int unsigned CW      = cnt_width(TIMEOUT);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_d, we_d, rw_d, fault_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d, res_d;
  logic [REG_W-1:0]  rd_d;
  logic              access, abort;

  assign access = mem_mem_read | mem_mem_write;
  assign abort  = (state_q == WAIT) & ~dmem_ack & (TIMEOUT != 0) &
                  (cnt_q == CW'(TO_LAST));

  // Upstream hold and branch redirect, both combinational.
  assign stall_mem    = (state_q == IDLE) ? access : ~(dmem_ack | abort);
  assign branch_taken = (state_q == IDLE) &
                        ((mem_branch & mem_zero) | (mem_branch_ne & ~mem_zero));

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = dmem_req;
    we_d    = dmem_we;
    addr_d  = dmem_addr;
    wdata_d = dmem_wdata;
    res_d   = wb_result;
    rd_d    = wb_rd;
    rw_d    = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = mem_mem_write;
          addr_d  = mem_alu_result[ADDR_W-1:0];
          wdata_d = mem_rs2_data;
          cnt_d   = '0;
        end else begin
          res_d = mem_alu_result;
          rd_d  = mem_rd;
          rw_d  = mem_reg_write;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          res_d   = mem_mem_to_reg ? dmem_rdata : mem_alu_result;
          rd_d    = mem_rd;
          rw_d    = mem_reg_write & ~mem_mem_write;
        end else if (abort) begin
          state_d = IDLE;
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      mem_fault    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      wb_result    <= res_d;
      wb_rd        <= rd_d;
      wb_reg_write <= rw_d;
      mem_fault    <= fault_d;
    end
  end

endmodule
